// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter: FSM states and
// transaction owner.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant between IFU and LSU. It remembers the last winner
// so that, on a tie, the other requester wins.
module mem_arb_rr
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic grant_en,
   input  logic ifu_req,
   input  logic lsu_req,
   output logic gnt_ifu,
   output logic gnt_lsu
);

   arb_owner_e last_owner_q, last_owner_d;

   always_comb begin
      gnt_ifu = grant_en & ifu_req & (~lsu_req | (last_owner_q == OWN_LSU));
      gnt_lsu = grant_en & lsu_req & (~ifu_req | (last_owner_q == OWN_IFU));
      last_owner_d = last_owner_q;
      if (gnt_ifu) begin
         last_owner_d = OWN_IFU;
      end else if (gnt_lsu) begin
         last_owner_d = OWN_LSU;
      end
   end

   // LSU counts as last winner out of reset, so the IFU wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_owner_q <= OWN_LSU;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with at
// most one transaction outstanding.
//
// state   | meaning
// IDLE    | no transaction; arbitrate and accept one request
// REQ     | mem_valid asserted with latched fields until mem_ready
// WAIT    | waiting for mem_rvalid; forwarded to the owner as rvalid
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_valid,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_ready,
   output logic                ifu_rvalid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_valid,
   input  logic                lsu_wen,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_ready,
   output logic                lsu_rvalid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_valid,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int MASK_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   arb_owner_e          owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic                grant_en, gnt_ifu, gnt_lsu;

   // Readies are held low while reset is asserted, even though IDLE is active.
   assign grant_en = (state_q == ST_IDLE) & rst;

   mem_arb_rr u_rr (
      .clk      (clk),
      .rst      (rst),
      .grant_en (grant_en),
      .ifu_req  (ifu_valid),
      .lsu_req  (lsu_valid),
      .gnt_ifu  (gnt_ifu),
      .gnt_lsu  (gnt_lsu)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wen_d      = wen_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      ifu_ready  = 1'b0;
      lsu_ready  = 1'b0;
      ifu_rvalid = 1'b0;
      lsu_rvalid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_ifu) begin
               ifu_ready = 1'b1;
               owner_d   = OWN_IFU;
               addr_d    = ifu_addr;
               wen_d     = 1'b0;
               wdata_d   = '0;
               wmask_d   = '0;
               state_d   = ST_REQ;
            end else if (gnt_lsu) begin
               lsu_ready = 1'b1;
               owner_d   = OWN_LSU;
               addr_d    = lsu_addr;
               wen_d     = lsu_wen;
               wdata_d   = lsu_wdata;
               wmask_d   = lsu_wmask;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               ifu_rvalid = (owner_q == OWN_IFU);
               lsu_rvalid = (owner_q == OWN_LSU);
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   assign mem_valid = (state_q == ST_REQ);
   assign mem_wen   = mem_valid & wen_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign ifu_rdata = mem_rdata;
   assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for arbitration
// and stray-response cases, then hand sequences for a stalled store and reset.
module tb_mem_arbiter;

   localparam logic [63:0] A_IFU = 64'h0000_0000_8000_0000;
   localparam logic [63:0] A_LSU = 64'h0000_0000_8000_1000;
   localparam logic [63:0] WDATA = 64'h1122_3344_5566_7788;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_valid = 1'b0;
   logic [63:0] ifu_addr = A_IFU;
   logic        ifu_ready, ifu_rvalid;
   logic [63:0] ifu_rdata;
   logic        lsu_valid = 1'b0;
   logic        lsu_wen = 1'b0;
   logic [63:0] lsu_addr = A_LSU;
   logic [63:0] lsu_wdata = 64'h0;
   logic [7:0]  lsu_wmask = 8'h0;
   logic        lsu_ready, lsu_rvalid;
   logic [63:0] lsu_rdata;
   logic        mem_valid, mem_wen;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = 64'h0;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .ifu_valid  (ifu_valid),
      .ifu_addr   (ifu_addr),
      .ifu_ready  (ifu_ready),
      .ifu_rvalid (ifu_rvalid),
      .ifu_rdata  (ifu_rdata),
      .lsu_valid  (lsu_valid),
      .lsu_wen    (lsu_wen),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_wmask  (lsu_wmask),
      .lsu_ready  (lsu_ready),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .mem_valid  (mem_valid),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   // flags = {ifu_ready, lsu_ready, mem_valid, mem_wen, ifu_rvalid, lsu_rvalid}
   typedef struct {
      logic        iv;
      logic        lv;
      logic        mr;
      logic        mrv;
      logic [63:0] rd;
      logic [5:0]  exp_flags;
      logic [63:0] exp_addr;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(logic iv, logic lv, logic mr, logic mrv,
                               logic [63:0] rd, logic [5:0] f, logic [63:0] a);
      vec_t v;
      v.iv = iv; v.lv = lv; v.mr = mr; v.mrv = mrv;
      v.rd = rd; v.exp_flags = f; v.exp_addr = a;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] flags();
      return {ifu_ready, lsu_ready, mem_valid, mem_wen, ifu_rvalid, lsu_rvalid};
   endfunction

   initial begin
      int pulses;

      // Both valid from reset: IFU, LSU, IFU; then stray responses, a stalled fetch.
      vecs[0]  = mk(1, 1, 0, 0, 64'h0,  6'b100000, 64'h0);
      vecs[1]  = mk(1, 1, 1, 0, 64'h0,  6'b001000, A_IFU);
      vecs[2]  = mk(1, 1, 0, 1, 64'hA1, 6'b000010, 64'h0);
      vecs[3]  = mk(1, 1, 0, 0, 64'h0,  6'b010000, 64'h0);
      vecs[4]  = mk(1, 1, 1, 0, 64'h0,  6'b001000, A_LSU);
      vecs[5]  = mk(1, 1, 0, 1, 64'hB2, 6'b000001, 64'h0);
      vecs[6]  = mk(1, 1, 0, 0, 64'h0,  6'b100000, 64'h0);
      vecs[7]  = mk(0, 0, 1, 0, 64'h0,  6'b001000, A_IFU);
      vecs[8]  = mk(0, 0, 0, 1, 64'hC3, 6'b000010, 64'h0);
      vecs[9]  = mk(0, 0, 0, 1, 64'hE5, 6'b000000, 64'h0);
      vecs[10] = mk(1, 0, 1, 0, 64'h0,  6'b100000, 64'h0);
      vecs[11] = mk(0, 0, 0, 1, 64'hF6, 6'b001000, A_IFU);
      vecs[12] = mk(0, 0, 1, 0, 64'h0,  6'b001000, A_IFU);
      vecs[13] = mk(0, 0, 0, 1, 64'hD4, 6'b000010, 64'h0);
      vecs[14] = mk(0, 0, 0, 0, 64'h0,  6'b000000, 64'h0);

      #12;
      check("reset_flags", {58'h0, flags()}, 64'h0);
      check("reset_addr", mem_addr, 64'h0);
      check("reset_wdata", mem_wdata, 64'h0);
      check("reset_wmask", {56'h0, mem_wmask}, 64'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         ifu_valid  = vecs[i].iv;
         lsu_valid  = vecs[i].lv;
         lsu_wen    = 1'b0;
         mem_ready  = vecs[i].mr;
         mem_rvalid = vecs[i].mrv;
         mem_rdata  = vecs[i].rd;
         @(negedge clk);
         check($sformatf("vec%0d_flags", i), {58'h0, flags()}, {58'h0, vecs[i].exp_flags});
         if (vecs[i].exp_flags[3])
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
         if (vecs[i].exp_flags[1])
            check($sformatf("vec%0d_ifu_rdata", i), ifu_rdata, vecs[i].rd);
         if (vecs[i].exp_flags[0])
            check($sformatf("vec%0d_lsu_rdata", i), lsu_rdata, vecs[i].rd);
      end

      // Store held off by mem_ready for four cycles while LSU inputs change.
      @(posedge clk);
      #1;
      lsu_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = A_LSU;
      lsu_wdata = WDATA; lsu_wmask = 8'h0F;
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      check("st_lsu_ready", {63'h0, lsu_ready}, 64'h1);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 64'h0;
         lsu_wdata = ~WDATA; lsu_wmask = 8'hFF;
         @(negedge clk);
         check($sformatf("st%0d_flags", c), {58'h0, flags()}, {58'h0, 6'b001100});
         check($sformatf("st%0d_addr", c), mem_addr, A_LSU);
         check($sformatf("st%0d_wdata", c), mem_wdata, WDATA);
         check($sformatf("st%0d_wmask", c), {56'h0, mem_wmask}, 64'h0F);
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      @(negedge clk);
      check("st_accept_wen", {63'h0, mem_wen}, 64'h1);
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         mem_ready  = 1'b0;
         mem_rvalid = 1'b1;
         @(negedge clk);
         if (lsu_rvalid) pulses++;
         check($sformatf("st_resp%0d_ifu_rvalid", c), {63'h0, ifu_rvalid}, 64'h0);
      end
      check("st_rvalid_pulses", 64'(pulses), 64'd1);
      lsu_addr = A_LSU; lsu_wdata = 64'h0; lsu_wmask = 8'h0;

      // Reset while waiting for a fetch response; the late response is dropped.
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0; ifu_valid = 1'b1;
      @(negedge clk);
      check("rw_grant", {63'h0, ifu_ready}, 64'h1);
      @(posedge clk);
      #1;
      ifu_valid = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check("rw_req", {63'h0, mem_valid}, 64'h1);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("rw_in_reset", {58'h0, flags()}, 64'h0);
      check("rw_in_reset_addr", mem_addr, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b1; mem_rdata = 64'h77;
      @(negedge clk);
      check("rw_late_resp", {58'h0, flags()}, 64'h0);
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0; ifu_valid = 1'b1;
      @(negedge clk);
      check("rw_next_grant", {58'h0, flags()}, {58'h0, 6'b100000});
      @(posedge clk);
      #1;
      ifu_valid = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check("rw_next_req", {58'h0, flags()}, {58'h0, 6'b001000});
      check("rw_next_addr", mem_addr, A_IFU);
      @(posedge clk);
      #1;
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      check("rw_next_resp", {58'h0, flags()}, {58'h0, 6'b000010});
      check("rw_next_rdata", ifu_rdata, 64'h1234_5678_9ABC_DEF0);
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
